// File: rtl/m92_irq_pkg.sv
// Shared definitions for the M92 interrupt scheduler: sequencer states,
// source bit positions, config register addresses and a saturating helper.
package m92_irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK1,
    ST_GAP1,
    ST_ACK2,
    ST_GAP2,
    ST_DONE
  } irq_state_e;

  localparam int SRC_VBL    = 0;
  localparam int SRC_DMA    = 1;
  localparam int SRC_RASTER = 2;
  localparam int SRC_SND    = 3;
  localparam int NUM_SRC    = 4;

  localparam logic [1:0] CFG_RASTER_LO = 2'd0;
  localparam logic [1:0] CFG_RASTER_HI = 2'd1;
  localparam logic [1:0] CFG_SRC_MASK  = 2'd2;
  localparam logic [1:0] CFG_STAT_CLR  = 2'd3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/m92_irq_stretch.sv
// Rising-edge detector plus retriggerable PULSE_LEN stretcher for one PIC source.
// M92_IRQ_STATS_EN adds a saturating count of accepted edges.
module m92_irq_stretch
  import m92_irq_pkg::*;
#(
  parameter int PULSE_LEN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        en,
  input  logic        lvl,
`ifdef M92_IRQ_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_cnt,
`endif
  output logic        pulse
);

  localparam int CW = $clog2(PULSE_LEN) + 1;
  localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);

  logic          lvl_q;
  logic [CW-1:0] cnt;
  logic          fire;

  assign fire  = en & lvl & ~lvl_q;
  assign pulse = (cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl_q <= 1'b0;
      cnt   <= '0;
    end else if (ce) begin
      lvl_q <= lvl;
      // A retrigger reloads the count, merging overlapping events into one pulse.
      if (!en)            cnt <= '0;
      else if (fire)      cnt <= LOAD;
      else if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

`ifdef M92_IRQ_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   stat_cnt <= '0;
    else if (ce) begin
      if (stat_clr)  stat_cnt <= '0;
      else if (fire) stat_cnt <= sat_inc16(stat_cnt);
    end
  end
`endif

endmodule

// File: rtl/m92_irq_ctrl.sv
// M92 interrupt scheduler: stretched intp sources, raster compare, and the
// INTA -> two-pulse PIC ack sequencer. M92_IRQ_STATS_EN adds statistics counters.
module m92_irq_ctrl
  import m92_irq_pkg::*;
#(
  parameter int         ACK_LEN      = 2,
  parameter int         GAP_LEN      = 2,
  parameter int         PULSE_LEN    = 4,
  parameter logic [7:0] SPURIOUS_VEC = 8'h07
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        cs,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [7:0]  din,
  input  logic        vblank,
  input  logic [8:0]  vcount,
  input  logic        dma_done,
  input  logic        snd_irq,
  output logic [7:0]  intp,
`ifdef M92_IRQ_STATS_EN
  input  logic [1:0]  stat_sel,
  output logic [15:0] stat_data,
`endif
  input  logic        pic_int_req,
  output logic        pic_int_ack,
  input  logic [7:0]  pic_int_vector,
  output logic        cpu_intr,
  input  logic        cpu_inta,
  output logic [7:0]  cpu_vec,
  output logic        cpu_vec_valid
);

  localparam int MAX_LEN = (ACK_LEN > GAP_LEN) ? ACK_LEN : GAP_LEN;
  localparam int CW      = $clog2(MAX_LEN) + 1;
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_LEN - 1);

  // ---------------------------------------------------------------- config
  logic       cfg_we;
  logic [8:0] raster_cmp;
  logic [3:0] src_en;

  assign cfg_we = cs & wr & ce;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raster_cmp <= 9'h1FF;
      src_en     <= 4'hF;
    end else if (cfg_we) begin
      case (addr)
        CFG_RASTER_LO: raster_cmp[7:0] <= din;
        CFG_RASTER_HI: raster_cmp[8]   <= din[0];
        CFG_SRC_MASK:  src_en          <= din[3:0];
        default:       ;
      endcase
    end
  end

  // ---------------------------------------------------------------- sources
  logic [8:0]         vcount_q;
  logic               raster_hit;
  logic [NUM_SRC-1:0] src_lvl;
  logic [NUM_SRC-1:0] src_pulse;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vcount_q <= '0;
    else if (ce)  vcount_q <= vcount;
  end

  // Only a line change can hit, so a static vcount never refires.
  assign raster_hit = (vcount != vcount_q) && (vcount == raster_cmp);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    src_lvl             = '0;
    src_lvl[SRC_VBL]    = vblank;
    src_lvl[SRC_DMA]    = dma_done;
    src_lvl[SRC_RASTER] = raster_hit;
    src_lvl[SRC_SND]    = snd_irq;
  end

`ifdef M92_IRQ_STATS_EN
  logic        stat_clr;
  logic [15:0] src_stat [NUM_SRC];
  assign stat_clr = cfg_we && (addr == CFG_STAT_CLR);
`endif

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    m92_irq_stretch #(.PULSE_LEN(PULSE_LEN)) u_stretch (
      .clk      (clk),
      .reset_n  (reset_n),
      .ce       (ce),
      .en       (src_en[i]),
      .lvl      (src_lvl[i]),
`ifdef M92_IRQ_STATS_EN
      .stat_clr (stat_clr),
      .stat_cnt (src_stat[i]),
`endif
      .pulse    (src_pulse[i])
    );
  end

  assign intp     = {4'b0000, src_pulse};
  assign cpu_intr = pic_int_req;

  // ---------------------------------------------------------------- INTA sequencer
  irq_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done_seen;
  logic          spurious;

  // A request already gone when INTA arrives never touches the PIC.
  assign spurious = (state == ST_IDLE) && cpu_inta && !pic_int_req;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (cpu_inta) state_n = pic_int_req ? ST_ACK1 : ST_DONE;
      end
      ST_ACK1: begin
        if (cnt == ACK_LAST) begin state_n = ST_GAP1; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      end
      ST_GAP1: begin
        if (cnt == GAP_LAST) begin state_n = ST_ACK2; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      end
      ST_ACK2: begin
        if (cnt == ACK_LAST) begin state_n = ST_GAP2; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      end
      ST_GAP2: begin
        if (cnt == GAP_LAST) begin state_n = ST_DONE; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      end
      ST_DONE: begin
        cnt_n = '0;
        if (done_seen && !cpu_inta) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      done_seen     <= 1'b0;
      pic_int_ack   <= 1'b0;
      cpu_vec       <= '0;
      cpu_vec_valid <= 1'b0;
    end else if (ce) begin
      state         <= state_n;
      cnt           <= cnt_n;
      pic_int_ack   <= (state_n == ST_ACK1) || (state_n == ST_ACK2);
      done_seen     <= (state == ST_DONE);
      cpu_vec_valid <= (state == ST_DONE) && !done_seen;
      // The PIC drives its vector after the first ack; sample one cycle into GAP1.
      if (spurious)                                cpu_vec <= SPURIOUS_VEC;
      else if ((state == ST_GAP1) && (cnt == '0))  cpu_vec <= pic_int_vector;
    end
  end

`ifdef M92_IRQ_STATS_EN
  logic [15:0] spur_stat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) spur_stat <= '0;
    else if (ce) begin
      if (stat_clr)      spur_stat <= '0;
      else if (spurious) spur_stat <= sat_inc16(spur_stat);
    end
  end

  // Slot 3 reports spurious acks in place of the sound count.
  always_comb begin
    stat_data = src_stat[SRC_VBL];
    case (stat_sel)
      2'd1:    stat_data = src_stat[SRC_DMA];
      2'd2:    stat_data = src_stat[SRC_RASTER];
      2'd3:    stat_data = spur_stat;
      default: ;
    endcase
  end
`endif

endmodule

// File: tb/tb_m92_irq_ctrl.sv
// Self-checking bench for m92_irq_ctrl: source vector table, INTA handshake
// sequences, and randomized sources against a timestamp-based reference model.
module tb_m92_irq_ctrl;

  localparam int         PULSE_LEN = 4;
  localparam int         ACK_LEN   = 2;
  localparam int         GAP_LEN   = 2;
  localparam int         LAT       = 2 * ACK_LEN + 2 * GAP_LEN + 2;
  localparam logic [7:0] SPUR_VEC  = 8'h07;

  logic       clk = 1'b0;
  logic       reset_n, ce, cs, wr;
  logic [1:0] addr;
  logic [7:0] din;
  logic       vblank, dma_done, snd_irq;
  logic [8:0] vcount;
  logic [7:0] intp;
  logic       pic_int_req, pic_int_ack;
  logic [7:0] pic_int_vector;
  logic       cpu_intr, cpu_inta;
  logic [7:0] cpu_vec;
  logic       cpu_vec_valid;

  always #5 clk = ~clk;

  m92_irq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .cs(cs), .wr(wr), .addr(addr), .din(din),
    .vblank(vblank), .vcount(vcount), .dma_done(dma_done), .snd_irq(snd_irq),
    .intp(intp), .pic_int_req(pic_int_req), .pic_int_ack(pic_int_ack),
    .pic_int_vector(pic_int_vector), .cpu_intr(cpu_intr), .cpu_inta(cpu_inta),
    .cpu_vec(cpu_vec), .cpu_vec_valid(cpu_vec_valid)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    ce = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       vb, dma, snd;
    logic [8:0] vc;
    logic       w;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t v(input logic vb, input logic dma, input logic snd,
                             input logic [8:0] vc, input logic w, input logic [1:0] a,
                             input logic [7:0] d, input logic [7:0] exp);
    vec_t r;
    r.vb = vb; r.dma = dma; r.snd = snd; r.vc = vc;
    r.w = w; r.a = a; r.d = d; r.exp = exp;
    return r;
  endfunction

  function automatic int rises(input logic [15:0] h);
    int   n = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (h[i] && !prev) n++;
      prev = h[i];
    end
    return n;
  endfunction

  // One CPU INTA transaction with a PIC presenting vec; req drops after edge drop_at.
  task automatic inta_seq(input logic req, input logic [7:0] vec, input int drop_at,
                          output logic [15:0] ack_h, output logic [15:0] val_h,
                          output logic [7:0] vec_v, output int lat);
    pic_int_req = req; pic_int_vector = vec; cpu_inta = 1'b1;
    ack_h = '0; val_h = '0; vec_v = '0; lat = -1;
    for (int e = 0; e < 16; e++) begin
      step();
      if (e == drop_at) pic_int_req = 1'b0;
      ack_h[e] = pic_int_ack;
      val_h[e] = cpu_vec_valid;
      if (cpu_vec_valid && lat < 0) begin
        lat = e + 1; vec_v = cpu_vec; cpu_inta = 1'b0;
      end
    end
    cpu_inta = 1'b0; pic_int_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t        tbl[$];
  logic [15:0] ack_h, val_h;
  logic [7:0]  vec_v;
  int          lat;

  initial begin
    reset_n = 1'b0; ce = 1'b0; cs = 1'b0; wr = 1'b0; addr = '0; din = '0;
    vblank = 1'b0; dma_done = 1'b0; snd_irq = 1'b0; vcount = '0;
    pic_int_req = 1'b0; pic_int_vector = '0; cpu_inta = 1'b0;

    // ----- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst intp", intp, 8'h00);
    check("rst ack", pic_int_ack, 1'b0);
    check("rst cpu_vec", cpu_vec, 8'h00);
    check("rst valid", cpu_vec_valid, 1'b0);
    reset_n = 1'b1;
    pic_int_req = 1'b1; #1;
    check("cpu_intr follows req", cpu_intr, 1'b1);
    pic_int_req = 1'b0; #1;
    check("cpu_intr follows req low", cpu_intr, 1'b0);

    // ----- source vector table: vb, dma, snd, vcount, wr, addr, din, expected intp
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h00));
    tbl.push_back(v(1,0,0,9'h000,0,0,8'h00,8'h01));
    tbl.push_back(v(1,0,0,9'h000,0,0,8'h00,8'h01));
    tbl.push_back(v(1,0,0,9'h000,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h00));
    tbl.push_back(v(1,0,0,9'h000,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h01));
    tbl.push_back(v(1,0,0,9'h000,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h00));
    tbl.push_back(v(0,1,0,9'h000,0,0,8'h00,8'h02));
    tbl.push_back(v(0,1,1,9'h000,0,0,8'h00,8'h0A));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h0A));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h0A));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h08));
    tbl.push_back(v(0,0,0,9'h000,0,0,8'h00,8'h00));
    tbl.push_back(v(0,0,0,9'h000,1,0,8'hF0,8'h00));
    tbl.push_back(v(0,0,0,9'h000,1,1,8'hFE,8'h00));
    tbl.push_back(v(0,0,0,9'h0EF,0,0,8'h00,8'h00));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h04));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h04));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h04));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h04));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h00));
    tbl.push_back(v(0,0,0,9'h0EF,1,2,8'hFB,8'h00));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h00));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h00));
    tbl.push_back(v(1,0,0,9'h0F0,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h01));
    tbl.push_back(v(0,0,0,9'h0F0,0,0,8'h00,8'h00));
    tbl.push_back(v(0,0,0,9'h0F0,1,3,8'h00,8'h00));
    tbl.push_back(v(1,0,0,9'h0F0,0,0,8'h00,8'h01));

    for (int i = 0; i < tbl.size(); i++) begin
      vblank = tbl[i].vb; dma_done = tbl[i].dma; snd_irq = tbl[i].snd; vcount = tbl[i].vc;
      cs = tbl[i].w; wr = tbl[i].w; addr = tbl[i].a; din = tbl[i].d;
      step();
      check($sformatf("tbl[%0d] intp", i), intp, tbl[i].exp);
    end
    cs = 1'b0; wr = 1'b0;

    // ----- normal two-pulse handshake
    inta_seq(1'b1, 8'h42, -1, ack_h, val_h, vec_v, lat);
    check("norm ack wave", ack_h, 16'h0033);
    check("norm ack rises", rises(ack_h), 2);
    check("norm valid wave", val_h, 16'h0200);
    check("norm latency", lat, LAT);
    check("norm vec", vec_v, 8'h42);

    // ----- spurious: request gone when INTA arrives
    inta_seq(1'b0, 8'h42, -1, ack_h, val_h, vec_v, lat);
    check("spur ack wave", ack_h, 16'h0000);
    check("spur valid wave", val_h, 16'h0002);
    check("spur vec", vec_v, SPUR_VEC);

    // ----- request dropping after ACK1 still completes normally
    inta_seq(1'b1, 8'h99, 1, ack_h, val_h, vec_v, lat);
    check("drop ack wave", ack_h, 16'h0033);
    check("drop vec", vec_v, 8'h99);

    // ----- reset during ACK2
    pic_int_req = 1'b1; pic_int_vector = 8'h5A; cpu_inta = 1'b1;
    repeat (5) step();
    check("pre-reset ack2 high", pic_int_ack, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async ack drop", pic_int_ack, 1'b0);
    check("reset cpu_vec", cpu_vec, 8'h00);
    check("reset valid", cpu_vec_valid, 1'b0);
    cpu_inta = 1'b0; pic_int_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    inta_seq(1'b1, 8'h5A, -1, ack_h, val_h, vec_v, lat);
    check("post-reset ack wave", ack_h, 16'h0033);
    check("post-reset vec", vec_v, 8'h5A);

    // ----- ce at 1-in-3: 3x stretch, frozen while ce=0
    begin
      int         stall_bad = 0;
      int         ack_clks  = 0;
      int         lat_clk   = -1;
      logic [7:0] vec3      = '0;
      logic [17:0] snap;
      pic_int_req = 1'b1; pic_int_vector = 8'h3C; cpu_inta = 1'b1;
      for (int c = 1; c <= 60; c++) begin
        ce = (c % 3 == 0);
        snap = {intp, pic_int_ack, cpu_vec, cpu_vec_valid};
        @(posedge clk); #1;
        if (!ce && (snap !== {intp, pic_int_ack, cpu_vec, cpu_vec_valid})) stall_bad++;
        if (pic_int_ack) ack_clks++;
        if (cpu_vec_valid && lat_clk < 0) begin
          lat_clk = c; vec3 = cpu_vec; cpu_inta = 1'b0;
        end
      end
      ce = 1'b1; pic_int_req = 1'b0; cpu_inta = 1'b0;
      check("ce/3 latency clks", lat_clk, 3 * LAT);
      check("ce/3 ack high clks", ack_clks, 3 * 2 * ACK_LEN);
      check("ce/3 no advance on ce=0", stall_bad, 0);
      check("ce/3 vec", vec3, 8'h3C);
    end

    // ----- randomized handshakes: vector, or the spurious code when req is absent
    for (int t = 0; t < 6; t++) begin
      logic       r  = ($urandom_range(3) != 0);
      logic [7:0] vv = 8'($urandom);
      int         dr = (r && $urandom_range(1) == 1) ? 1 + $urandom_range(5) : -1;
      inta_seq(r, vv, dr, ack_h, val_h, vec_v, lat);
      check($sformatf("rnd hs%0d vec", t), vec_v, r ? vv : SPUR_VEC);
      check($sformatf("rnd hs%0d latency", t), lat, r ? LAT : 2);
      check($sformatf("rnd hs%0d ack pulses", t), rises(ack_h), r ? 2 : 0);
    end

    // ----- randomized sources against a timestamp model
    vblank = 1'b0; dma_done = 1'b0; snd_irq = 1'b0; vcount = '0;
    do_reset();
    begin
      logic [3:0] m_en    = 4'hF;
      logic [8:0] m_cmp   = 9'h1FF;
      logic [3:0] m_prev  = '0;
      logic [8:0] m_vprev = '0;
      int         last_ev [4] = '{-100, -100, -100, -100};
      logic [3:0] ev;
      logic [7:0] exp;
      logic       do_wr;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(3) == 0) vblank   = ~vblank;
        if ($urandom_range(3) == 0) dma_done = ~dma_done;
        if ($urandom_range(3) == 0) snd_irq  = ~snd_irq;
        pic_int_req = 1'($urandom_range(1));
        case ($urandom_range(5))
          0:       vcount = m_cmp;
          1:       vcount = m_cmp - 9'd1;
          2:       vcount = 9'($urandom);
          default: ;
        endcase
        do_wr = ($urandom_range(15) == 0);
        cs = do_wr | 1'($urandom_range(1));
        wr = do_wr;
        addr = 2'($urandom_range(3));
        din = 8'($urandom);

        ev[0] = vblank & ~m_prev[0];
        ev[1] = dma_done & ~m_prev[1];
        ev[2] = (vcount != m_vprev) && (vcount == m_cmp);
        ev[3] = snd_irq & ~m_prev[3];
        for (int i = 0; i < 4; i++) begin
          if (!m_en[i])   last_ev[i] = -100;
          else if (ev[i]) last_ev[i] = k;
        end
        m_prev = {snd_irq, 1'b0, dma_done, vblank};
        m_vprev = vcount;
        if (do_wr) begin
          case (addr)
            2'd0:    m_cmp[7:0] = din;
            2'd1:    m_cmp[8]   = din[0];
            2'd2:    m_en       = din[3:0];
            default: ;
          endcase
        end

        step();
        exp = '0;
        for (int i = 0; i < 4; i++) exp[i] = ((k - last_ev[i]) < PULSE_LEN);
        check($sformatf("rnd intp k=%0d", k), intp, exp);
        check($sformatf("rnd cpu_intr k=%0d", k), cpu_intr, pic_int_req);
      end
      cs = 1'b0; wr = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
